serial_bit_feeder: RTL and testbench



---
 rtl/serial_bit_feeder.sv | 115 +++++++++++
 tb/tb_serial_bit_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out one bit per strobe.
// A one-entry holding register lets the next word follow the current one with no idle bit.
module serial_bit_feeder #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_VAL  = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                shift_strobe,
  output logic                serial_out,
  output logic                bit_valid,
  output logic                word_done,
  output logic                busy
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BITS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e              r_state, w_state_next;
  logic [NUM_BITS-1:0] r_hold, w_hold_next;
  logic [NUM_BITS-1:0] r_shift, w_shift_next;
  logic                r_hold_full, w_hold_full_next;
  logic [CntW-1:0]     r_cnt, w_cnt_next;
  logic                r_word_done, w_word_done_next;
  logic                w_accept;
  logic                w_last;
  logic                w_out_bit;

  assign w_accept  = data_valid & ~r_hold_full;
  assign w_last    = (r_cnt == LastCnt);
  assign w_out_bit = MSB_FIRST ? r_shift[NUM_BITS-1] : r_shift[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= StIdle;
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold      <= w_hold_next;
      r_shift     <= w_shift_next;
      r_hold_full <= w_hold_full_next;
      r_cnt       <= w_cnt_next;
      r_word_done <= w_word_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hold_next      = r_hold;
    w_shift_next     = r_shift;
    w_hold_full_next = r_hold_full;
    w_cnt_next       = r_cnt;
    w_word_done_next = 1'b0;

    // Accept and reload are exclusive: accept needs the hold empty, reload needs it full.
    if (w_accept) begin
      w_hold_next      = data_in;
      w_hold_full_next = 1'b1;
    end

    case (r_state)
      StIdle: begin
        if (r_hold_full) begin
          w_shift_next     = r_hold;
          w_hold_full_next = 1'b0;
          w_cnt_next       = '0;
          w_state_next     = StShift;
        end
      end
      StShift: begin
        if (shift_strobe) begin
          if (w_last) begin
            w_word_done_next = 1'b1;
            // Only a word already held counts; one accepted on this edge waits a bubble.
            if (r_hold_full) begin
              w_shift_next     = r_hold;
              w_hold_full_next = 1'b0;
              w_cnt_next       = '0;
            end else begin
              w_shift_next = '0;
              w_cnt_next   = '0;
              w_state_next = StIdle;
            end
          end else begin
            w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
            w_cnt_next   = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign data_ready = ~r_hold_full;
  assign bit_valid  = (r_state == StShift);
  assign busy       = (r_state == StShift) | r_hold_full;
  assign serial_out = (r_state == StShift) ? w_out_bit : IDLE_VAL;
  assign word_done  = r_word_done;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed self-checking bench for serial_bit_feeder (NUM_BITS=8, MSB first, idle level 0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_bit_feeder;

  logic       clk;
  logic       n_rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       shift_strobe;
  logic       serial_out;
  logic       bit_valid;
  logic       word_done;
  logic       busy;

  int tests_run;
  int tests_failed;

  serial_bit_feeder #(
    .NUM_BITS (8),
    .MSB_FIRST(1'b1),
    .IDLE_VAL (1'b0)
  ) u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .shift_strobe(shift_strobe),
    .serial_out  (serial_out),
    .bit_valid   (bit_valid),
    .word_done   (word_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; data_in = '0; data_valid = 1'b0; shift_strobe = 1'b0;
    tick();
    tick();
    tests_run++; if (serial_out !== 1'b0) begin tests_failed++;
      $display("FAIL reset_serial_out: got %b want 0", serial_out); end
    tests_run++; if (bit_valid !== 1'b0) begin tests_failed++;
      $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
    tests_run++; if (data_ready !== 1'b1) begin tests_failed++;
      $display("FAIL reset_data_ready: got %b want 1", data_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (word_done !== 1'b0) begin tests_failed++;
      $display("FAIL reset_word_done: got %b want 0", word_done); end
    #2 n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    int vcnt;
    int dcnt;
    w = 8'hD0; vcnt = 0; dcnt = 0;
    data_in = w; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    tests_run++; if (data_ready !== 1'b0 || busy !== 1'b1 || bit_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: ready=%b busy=%b valid=%b want 0 1 0",
               data_ready, busy, bit_valid);
    end
    data_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (serial_out !== w[7-i]) begin tests_failed++;
        $display("FAIL single_bit%0d: serial_out=%b want %b", i, serial_out, w[7-i]); end
      vcnt += int'(bit_valid);
      dcnt += int'(word_done);
      tick();
    end
    tests_run++; if (vcnt != 8 || dcnt != 0) begin tests_failed++;
      $display("FAIL single_counts: bit_valid cycles=%0d word_done cycles=%0d want 8 0",
               vcnt, dcnt);
    end
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0 || serial_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end: done=%b valid=%b out=%b want 1 0 0",
               word_done, bit_valid, serial_out);
    end
    shift_strobe = 1'b0;
    tick();
    tests_run++; if (word_done !== 1'b0 || busy !== 1'b0) begin tests_failed++;
      $display("FAIL single_done_pulse: done=%b busy=%b want 0 0", word_done, busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic        exp_rdy;
    s = 16'hD00D;
    data_in = 8'hD0; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    data_in = 8'h0D;
    tick();
    for (int j = 0; j < 16; j++) begin
      exp_rdy = (j == 0 || j >= 8);
      tests_run++; if (serial_out !== s[15-j] || bit_valid !== 1'b1) begin tests_failed++;
        $display("FAIL b2b_bit%0d: out=%b valid=%b want %b 1", j, serial_out, bit_valid,
                 s[15-j]);
      end
      tests_run++; if (word_done !== (j == 8)) begin tests_failed++;
        $display("FAIL b2b_done%0d: got %b want %b", j, word_done, (j == 8)); end
      tests_run++; if (data_ready !== exp_rdy) begin tests_failed++;
        $display("FAIL b2b_ready%0d: got %b want %b", j, data_ready, exp_rdy); end
      if (j == 1) data_valid = 1'b0;
      tick();
    end
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: done=%b valid=%b busy=%b want 1 0 0", word_done, bit_valid, busy);
    end
    shift_strobe = 1'b0;
    tick();
  endtask

  task automatic test_strobe_pacing();
    logic [7:0] w;
    w = 8'hA5;
    data_in = w; data_valid = 1'b1; shift_strobe = 1'b0;
    tick();
    data_valid = 1'b0;
    tick();
    for (int c = 0; c < 24; c++) begin
      tests_run++; if (serial_out !== w[7-(c/3)] || bit_valid !== 1'b1) begin tests_failed++;
        $display("FAIL pace_cyc%0d: out=%b valid=%b want %b 1", c, serial_out, bit_valid,
                 w[7-(c/3)]);
      end
      shift_strobe = (c % 3 == 2);
      tick();
    end
    shift_strobe = 1'b0;
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0) begin tests_failed++;
      $display("FAIL pace_end: done=%b valid=%b want 1 0", word_done, bit_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [23:0] s;
    logic        exp_rdy;
    s = 24'h3C965A;
    data_in = 8'h3C; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int j = 0; j < 24; j++) begin
      exp_rdy = (j == 0 || j == 8 || j >= 16);
      tests_run++; if (serial_out !== s[23-j] || bit_valid !== 1'b1) begin tests_failed++;
        $display("FAIL bp_bit%0d: out=%b valid=%b want %b 1", j, serial_out, bit_valid,
                 s[23-j]);
      end
      tests_run++; if (data_ready !== exp_rdy) begin tests_failed++;
        $display("FAIL bp_ready%0d: got %b want %b", j, data_ready, exp_rdy); end
      tests_run++; if (word_done !== (j == 8 || j == 16)) begin tests_failed++;
        $display("FAIL bp_done%0d: got %b want %b", j, word_done, (j == 8 || j == 16)); end
      if (j == 0) begin data_in = 8'h96; data_valid = 1'b1; end
      if (j == 1) data_in = 8'h5A;
      if (j == 9) data_valid = 1'b0;
      tick();
    end
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0) begin tests_failed++;
      $display("FAIL bp_end: done=%b valid=%b want 1 0", word_done, bit_valid); end
    shift_strobe = 1'b0;
    tick();
  endtask

  task automatic test_accept_on_final_edge();
    logic [7:0] w;
    w = 8'hC3;
    data_in = w; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int j = 0; j < 8; j++) begin
      tests_run++; if (serial_out !== w[7-j]) begin tests_failed++;
        $display("FAIL fe_bit%0d: out=%b want %b", j, serial_out, w[7-j]); end
      if (j == 7) begin data_in = 8'h81; data_valid = 1'b1; end
      tick();
    end
    data_valid = 1'b0;
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0 || serial_out !== 1'b0 ||
                     data_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fe_bubble: done=%b valid=%b out=%b ready=%b busy=%b want 1 0 0 0 1",
               word_done, bit_valid, serial_out, data_ready, busy);
    end
    tick();
    tests_run++; if (bit_valid !== 1'b1 || serial_out !== 1'b1 || word_done !== 1'b0 ||
                     data_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fe_reload: valid=%b out=%b done=%b ready=%b want 1 1 0 1",
               bit_valid, serial_out, word_done, data_ready);
    end
    for (int j = 0; j < 8; j++) tick();
    shift_strobe = 1'b0;
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0) begin tests_failed++;
      $display("FAIL fe_end: done=%b valid=%b want 1 0", word_done, bit_valid); end
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    data_in = 8'hFF; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    data_in = 8'h55; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    tests_run++; if (busy !== 1'b1 || data_ready !== 1'b0 || serial_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_pre: busy=%b ready=%b out=%b want 1 0 1", busy, data_ready, serial_out);
    end
    #2 n_rst = 1'b0;
    #1;
    tests_run++; if (serial_out !== 1'b0 || bit_valid !== 1'b0 || data_ready !== 1'b1 ||
                     busy !== 1'b0 || word_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_async: out=%b valid=%b ready=%b busy=%b done=%b want 0 0 1 0 0",
               serial_out, bit_valid, data_ready, busy, word_done);
    end
    shift_strobe = 1'b0;
    tick();
    tick();
    #2 n_rst = 1'b1;
    tick();
    tests_run++; if (bit_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++;
      $display("FAIL rm_discard: valid=%b busy=%b want 0 0", bit_valid, busy); end
    w = 8'h81;
    data_in = w; data_valid = 1'b1; shift_strobe = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int j = 0; j < 8; j++) begin
      tests_run++; if (serial_out !== w[7-j] || bit_valid !== 1'b1 || word_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL rm_bit%0d: out=%b valid=%b done=%b want %b 1 0", j, serial_out,
                 bit_valid, word_done, w[7-j]);
      end
      tick();
    end
    shift_strobe = 1'b0;
    tests_run++; if (word_done !== 1'b1 || bit_valid !== 1'b0) begin tests_failed++;
      $display("FAIL rm_end: done=%b valid=%b want 1 0", word_done, bit_valid); end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_strobe_pacing();
    test_backpressure();
    test_accept_on_final_edge();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
